// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch timekeeping datapath.
//   - field limits and widths for centiseconds, seconds and minutes
//   - default prescaler ratio (100 MHz clk to a 100 Hz tick)
//   - prescaler width helper
package stopwatch_pkg;

  localparam int unsigned CSEC_MAX = 99;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;

  localparam int unsigned CSEC_W = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;

  localparam int unsigned TICK_DIV_DEFAULT = 1_000_000;

  // clog2 of the divide ratio, but never narrower than one bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Connection between the stopwatch mode controller / display mux and stopwatch_core.
//   i_run_on : level, 1 = count
//   i_clr_on : level, 1 = clear (overrides i_run_on)
//   o_csec   : centiseconds 0..99
//   o_sec    : seconds 0..59
//   o_min    : minutes 0..59
//   o_tick   : one-cycle pulse per centisecond increment
//   o_wrap   : one-cycle pulse on 59:59.99 -> 00:00.00
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic              i_run_on;
  logic              i_clr_on;
  logic [CSEC_W-1:0] o_csec;
  logic [SEC_W-1:0]  o_sec;
  logic [MIN_W-1:0]  o_min;
  logic              o_tick;
  logic              o_wrap;

  modport master (
    output i_run_on, i_clr_on,
    input  o_csec, o_sec, o_min, o_tick, o_wrap
  );

  modport slave (
    input  i_run_on, i_clr_on,
    output o_csec, o_sec, o_min, o_tick, o_wrap
  );

endinterface

// File: rtl/stopwatch_tick_gen.sv
// Prescaler producing one tick_en per TICK_DIV enabled clk edges.
//   clk, reset : clock and asynchronous active-high reset
//   en         : advance the prescaler (already masked by clr)
//   clr        : zero the prescaler
//   tick_en    : high during the cycle whose edge completes a tick period
module stopwatch_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_en
);

  localparam int unsigned PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic          at_last;

  assign at_last = (presc_q == LAST);
  assign tick_en = en & at_last;

  // Holding while !en keeps the partial tick across a pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (clr) begin
      presc_q <= '0;
    end else if (en) begin
      if (at_last) presc_q <= '0;
      else         presc_q <= presc_q + PW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping datapath: prescaler plus csec/sec/min cascade.
//   clk, reset : clock and asynchronous active-high reset
//   sw         : stopwatch_if.slave (run/clear levels in, registered time fields and pulses out)
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input logic       clk,
  input logic       reset,
  stopwatch_if.slave sw
);

  logic clr;
  logic en;
  logic tick_en;

  assign clr = sw.i_clr_on;
  assign en  = sw.i_run_on & ~sw.i_clr_on;

  stopwatch_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .tick_en (tick_en)
  );

  logic [CSEC_W-1:0] csec_q, csec_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;

  logic csec_last, sec_last, min_last;

  assign csec_last = (csec_q == CSEC_W'(CSEC_MAX));
  assign sec_last  = (sec_q  == SEC_W'(SEC_MAX));
  assign min_last  = (min_q  == MIN_W'(MIN_MAX));

  // Whole cascade resolves in one step so all three fields change on the same edge.
  always_comb begin
    csec_d = csec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (clr) begin
      csec_d = '0;
      sec_d  = '0;
      min_d  = '0;
    end else if (tick_en) begin
      tick_d = 1'b1;
      if (csec_last) begin
        csec_d = '0;
        if (sec_last) begin
          sec_d = '0;
          if (min_last) begin
            min_d  = '0;
            wrap_d = 1'b1;
          end else begin
            min_d = min_q + MIN_W'(1);
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end else begin
        csec_d = csec_q + CSEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      csec_q <= csec_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign sw.o_csec = csec_q;
  assign sw.o_sec  = sec_q;
  assign sw.o_min  = min_q;
  assign sw.o_tick = tick_q;
  assign sw.o_wrap = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: one instance with TICK_DIV=4 (table, sequences,
// randomized run against a model) and one with TICK_DIV=1 (full rollover).
module tb_stopwatch_core;

  localparam int DIV4 = 4;
  localparam int TOTAL_CS = 60 * 60 * 100;

  logic clk;
  logic reset;

  stopwatch_if sw4 ();
  stopwatch_if sw1 ();

  stopwatch_core #(
    .TICK_DIV (4)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw4.slave)
  );

  stopwatch_core #(
    .TICK_DIV (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: elapsed centiseconds plus enabled edges since the last tick.
  int m_total = 0;
  int m_phase = 0;
  bit m_tick  = 0;
  bit m_wrap  = 0;

  task automatic model_reset();
    m_total = 0;
    m_phase = 0;
    m_tick  = 0;
    m_wrap  = 0;
  endtask

  task automatic model_step(input bit run, input bit clr);
    m_tick = 0;
    m_wrap = 0;
    if (clr) begin
      m_total = 0;
      m_phase = 0;
    end else if (run) begin
      m_phase = m_phase + 1;
      if (m_phase == DIV4) begin
        m_phase = 0;
        m_total = (m_total + 1) % TOTAL_CS;
        m_tick  = 1;
        m_wrap  = (m_total == 0);
      end
    end
  endtask

  task automatic check(input string name, input bit use1, input int ec, input int es,
                       input int em, input bit et, input bit ew);
    int ac, as, am;
    bit at, aw;
    if (use1) begin
      ac = int'(sw1.o_csec); as = int'(sw1.o_sec); am = int'(sw1.o_min);
      at = sw1.o_tick;       aw = sw1.o_wrap;
    end else begin
      ac = int'(sw4.o_csec); as = int'(sw4.o_sec); am = int'(sw4.o_min);
      at = sw4.o_tick;       aw = sw4.o_wrap;
    end
    tests++;
    if (ac !== ec || as !== es || am !== em || at !== et || aw !== ew) begin
      fails++;
      $display("FAIL %s: got min=%0d sec=%0d csec=%0d tick=%0d wrap=%0d, expected min=%0d sec=%0d csec=%0d tick=%0d wrap=%0d",
               name, am, as, ac, at, aw, em, es, ec, et, ew);
    end
  endtask

  task automatic check_model(input string name);
    check(name, 1'b0, m_total % 100, (m_total / 100) % 60, m_total / 6000, m_tick, m_wrap);
  endtask

  // One edge on the TICK_DIV=4 instance, checked against the model.
  task automatic step4(input bit run, input bit clr, input string name);
    sw4.i_run_on = run;
    sw4.i_clr_on = clr;
    @(posedge clk);
    #1;
    model_step(run, clr);
    check_model(name);
  endtask

  typedef struct {
    bit run;
    bit clr;
    int csec;
    bit tick;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Run 8 edges: ticks on edges 4 and 8.
    for (int i = 1; i <= 8; i++) tbl.push_back('{1'b1, 1'b0, i / 4, (i % 4) == 0});
    tbl.push_back('{1'b0, 1'b1, 0, 1'b0});
    // Pause keeps phase: 3 run, 10 stop, 1 run completes the tick.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b0, 0, 1'b0});
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1, 1'b0});

    // Reset with run requested: outputs zero before any edge and throughout.
    reset = 1'b1;
    sw4.i_run_on = 1'b1; sw4.i_clr_on = 1'b0;
    sw1.i_run_on = 1'b0; sw1.i_clr_on = 1'b0;
    #1;
    check("reset_async4", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("reset_async1", 1'b1, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    end
    sw4.i_run_on = 1'b0;
    reset = 1'b0;
    model_reset();

    // Table-driven run/pause vectors.
    foreach (tbl[i]) begin
      sw4.i_run_on = tbl[i].run;
      sw4.i_clr_on = tbl[i].clr;
      @(posedge clk);
      #1;
      model_step(tbl[i].run, tbl[i].clr);
      check($sformatf("table[%0d]", i), 1'b0, tbl[i].csec, 0, 0, tbl[i].tick, 1'b0);
    end

    // Clear priority: reach csec=37, then clear with run held.
    step4(1'b0, 1'b1, "pre_clear");
    for (int i = 0; i < 37 * 4; i++) step4(1'b1, 1'b0, "run_to_37");
    check("at_37", 1'b0, 37, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step4(1'b1, 1'b1, "clear_wins");
      check("clear_zero", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step4(1'b1, 1'b0, "release_no_tick");
    check("release_pre", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    step4(1'b1, 1'b0, "release_tick");
    check("release_first_tick", 1'b0, 1, 0, 0, 1'b1, 1'b0);

    // Async reset mid-count at 0:03.50.
    step4(1'b0, 1'b1, "pre_mid");
    for (int i = 0; i < 350 * 4; i++) step4(1'b1, 1'b0, "run_to_350");
    check("at_3_50", 1'b0, 50, 3, 0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_async", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    sw4.i_run_on = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step4(1'b1, 1'b0, "resume");
    check("resume_tick", 1'b0, 1, 0, 0, 1'b1, 1'b0);

    // Randomized run/stop/clear against the model.
    for (int i = 0; i < 600; i++)
      step4($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, "random");
    sw4.i_run_on = 1'b0;
    sw4.i_clr_on = 1'b0;

    // Full rollover on the TICK_DIV=1 instance.
    sw1.i_run_on = 1'b1;
    repeat (99) @(posedge clk);
    #1;
    check("div1_csec99", 1'b1, 99, 0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("div1_carry_sec", 1'b1, 0, 1, 0, 1'b1, 1'b0);
    repeat (TOTAL_CS - 1 - 100) @(posedge clk);
    #1;
    check("div1_59_59_99", 1'b1, 99, 59, 59, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("div1_wrap", 1'b1, 0, 0, 0, 1'b1, 1'b1);
    sw1.i_run_on = 1'b0;
    @(posedge clk);
    #1;
    check("div1_after_wrap", 1'b1, 0, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Timekeeping datapath driven by the stopwatch mode controller's level outputs, run_on and clr_on.
- Divides clk down to a 100 Hz tick and counts centiseconds, seconds and minutes while running. Holds the count when stopped and zeroes it when cleared.
- Outputs feed the seven-segment display mux.

Parameters:
- TICK_DIV, 1_000_000: clk cycles per centisecond tick (100 MHz / 100 Hz). Must be >= 1. The bench uses 4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- i_run_on  in  1  level, 1 = count
- i_clr_on  in  1  level, 1 = clear; overrides i_run_on
- o_csec  out  7  centiseconds, 0..99
- o_sec  out  6  seconds, 0..59
- o_min  out  6  minutes, 0..59
- o_tick  out  1  one-cycle pulse on every centisecond increment
- o_wrap  out  1  one-cycle pulse when 59:59.99 rolls to 00:00.00

Behaviour:
- Reset (asynchronous) drives all of the following to 0 immediately, including mid-count: prescaler, o_csec, o_sec, o_min, o_tick, o_wrap.
- All outputs are registered. There is no combinational path from the inputs to the outputs.
- Enable rules, evaluated at each clk edge:
  - clr = i_clr_on.
  - en = i_run_on & ~i_clr_on.
- Prescaler:
  - Counter of width clog2(TICK_DIV), minimum 1 bit.
  - If clr: prescaler <= 0.
  - Else if en: if prescaler == TICK_DIV-1, then prescaler <= 0 and tick_en = 1; otherwise prescaler increments.
  - Else: prescaler holds. A pause preserves the partial tick.
- Counter cascade, updated on the edge where tick_en = 1:
  - o_csec increments. At 99 it wraps to 0 and carries.
  - On carry, o_sec increments. At 59 it wraps to 0 and carries.
  - On carry, o_min increments. At 59 it wraps to 0 and o_wrap is asserted.
  - All three fields update on the same edge, so no intermediate value is ever visible.
- Pulse outputs:
  - o_tick <= tick_en on every edge; it is high exactly one cycle per tick.
  - o_wrap <= tick_en & full-rollover condition.
- Latency:
  - After i_run_on rises from a cleared state, the first o_csec change and o_tick occur on the TICK_DIV-th enabled edge.
  - With TICK_DIV=1, every enabled edge is a tick.
- Clear:
  - On each edge with i_clr_on=1, all counters and the prescaler are set to 0. o_tick and o_wrap are 0 on that edge.
  - Clear held: the count stays 0.
  - Clear released with i_run_on=0: the count stays 0.
  - Clear released with i_run_on=1: counting starts from prescaler 0.
- Simultaneous i_run_on=1 and i_clr_on=1 is illegal from the controller but defined: clear wins.
- Stop (i_run_on=0, i_clr_on=0): all state holds and pulses are 0.
- Out-of-range field values are unreachable. The wrap compares use ==, and no saturation is required.

Decomposition:
- stopwatch_pkg holds:
  - CSEC_MAX=99, SEC_MAX=59, MIN_MAX=59.
  - Widths CSEC_W=7, SEC_W=6, MIN_W=6.
  - Default TICK_DIV.
- One sub-module, stopwatch_tick_gen:
  - Contains the prescaler.
  - Inputs: clk, reset, en, clr. Output: tick_en.
  - Parameter: TICK_DIV.
  - The cascade stays in stopwatch_core.

Test Plan (TICK_DIV=4 unless stated):
- Reset: assert reset for 3 cycles with i_run_on=1 -> o_csec=o_sec=o_min=0, o_tick=o_wrap=0 throughout. Outputs go to 0 asynchronously, before the next clk edge.
- Run: i_run_on=1 for 8 edges -> o_tick high on edges 4 and 8, one cycle each, and o_csec=2 after edge 8.
- Pause preserves phase: 3 enabled edges, then 10 edges with i_run_on=0 (o_csec=0, no tick), then 1 enabled edge -> o_csec=1 and o_tick=1 on that edge.
- Full rollover: TICK_DIV=1, run 359_999 edges -> o_min=59, o_sec=59, o_csec=99. The next edge gives 0/0/0 with o_wrap=1 and o_tick=1 for one cycle. A carry check of o_csec 99->0 with o_sec 0->1 happens at edge 100.
- Clear priority: run to o_csec=37, then i_clr_on=1 with i_run_on=1 for 5 edges -> all outputs 0 from the first clear edge, with no o_tick. Releasing clear with i_run_on=1 gives the first tick 4 edges later.
- Async reset mid-count: reset pulses between edges at o_sec=3, o_csec=50 -> outputs are 0 before the next edge, and counting resumes from 0 after deassertion with i_run_on=1.
